// File: rtl/debug_uart_tx_sched.sv
// debug_uart_tx_sched
// Shares the single debug UART transmitter between CPU MMIO writes and a
// hardware trace byte stream. CPU bytes are queued in a small FIFO. The
// two sources are served round-robin, one byte per uart_tx transfer.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   cpu_wr_en/_data     CPU byte write strobe and data
//   cpu_ovf_clr         clears the sticky overflow flag
//   trace_en            enables the trace source
//   trace_req/_data     trace byte valid (held until ack) and data
//   trace_ack           one-cycle accept pulse, coincident with the launch
//   uart_tx_en/_data    launch strobe and byte to uart_tx
//   uart_tx_busy        busy flag from uart_tx
//   fifo_count          CPU FIFO occupancy
//   fifo_full           fifo_count == FIFO_DEPTH
//   overflow            sticky: a CPU byte was dropped
//   sched_busy          a transfer is in progress or CPU bytes are queued
module debug_uart_tx_sched #(
  parameter int FIFO_DEPTH   = 4,
  parameter int BUSY_TIMEOUT = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cpu_wr_en,
  input  logic [7:0]                    cpu_wr_data,
  input  logic                          cpu_ovf_clr,
  input  logic                          trace_en,
  input  logic                          trace_req,
  input  logic [7:0]                    trace_data,
  output logic                          trace_ack,
  output logic                          uart_tx_en,
  output logic [7:0]                    uart_tx_data,
  input  logic                          uart_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_full,
  output logic                          overflow,
  output logic                          sched_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  typedef enum logic {
    SRC_CPU   = 1'b0,
    SRC_TRACE = 1'b1
  } src_t;

  logic [7:0]    fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [TW-1:0] tmo_cnt_r;
  logic [TW-1:0] tmo_cnt_nxt_s;
  src_t          last_grant_r;
  src_t          last_grant_nxt_s;

  logic          tx_en_nxt_s;
  logic [7:0]    tx_data_nxt_s;
  logic          trace_ack_nxt_s;

  logic          cpu_pend_s;
  logic          trc_pend_s;
  logic          grant_cpu_s;
  logic          grant_trc_s;
  logic          full_s;
  logic          push_s;
  logic          pop_s;
  logic          drop_s;

  assign full_s     = (count_r == CW'(FIFO_DEPTH));
  assign cpu_pend_s = (count_r != {CW{1'b0}});
  assign trc_pend_s = trace_en & trace_req;

  // A pop in the same cycle frees a slot, so a write into a full FIFO is
  // still accepted when the head byte is being launched.
  assign pop_s  = grant_cpu_s;
  assign push_s = cpu_wr_en & (~full_s | pop_s);
  assign drop_s = cpu_wr_en & ~push_s;

  assign fifo_count = count_r;
  assign fifo_full  = full_s;
  assign overflow   = overflow_r;
  assign sched_busy = (state_r != ST_IDLE) | cpu_pend_s;

  // Round-robin arbiter: only grants from IDLE while uart_tx is free.
  always_comb begin
    grant_cpu_s = 1'b0;
    grant_trc_s = 1'b0;
    if ((state_r == ST_IDLE) && !uart_tx_busy) begin
      if (cpu_pend_s && trc_pend_s) begin
        if (last_grant_r == SRC_TRACE) begin
          grant_cpu_s = 1'b1;
        end else begin
          grant_trc_s = 1'b1;
        end
      end else if (cpu_pend_s) begin
        grant_cpu_s = 1'b1;
      end else if (trc_pend_s) begin
        grant_trc_s = 1'b1;
      end else begin
        grant_cpu_s = 1'b0;
        grant_trc_s = 1'b0;
      end
    end else begin
      grant_cpu_s = 1'b0;
      grant_trc_s = 1'b0;
    end
  end

  // Next-state and next-output decode for the launch FSM.
  always_comb begin
    state_nxt_s      = state_r;
    tmo_cnt_nxt_s    = tmo_cnt_r;
    last_grant_nxt_s = last_grant_r;
    tx_en_nxt_s      = 1'b0;
    tx_data_nxt_s    = uart_tx_data;
    trace_ack_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tmo_cnt_nxt_s = {TW{1'b0}};
        if (grant_cpu_s) begin
          tx_en_nxt_s      = 1'b1;
          tx_data_nxt_s    = fifo_mem_r[rd_ptr_r];
          last_grant_nxt_s = SRC_CPU;
          state_nxt_s      = ST_WAIT_BUSY;
        end else if (grant_trc_s) begin
          tx_en_nxt_s      = 1'b1;
          tx_data_nxt_s    = trace_data;
          trace_ack_nxt_s  = 1'b1;
          last_grant_nxt_s = SRC_TRACE;
          state_nxt_s      = ST_WAIT_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_BUSY: begin
        // uart_tx must acknowledge the launch by raising busy; if it never
        // does, the byte is abandoned so the scheduler cannot lock up.
        if (uart_tx_busy) begin
          tmo_cnt_nxt_s = {TW{1'b0}};
          state_nxt_s   = ST_WAIT_DONE;
        end else if (tmo_cnt_r == TW'(BUSY_TIMEOUT - 1)) begin
          tmo_cnt_nxt_s = {TW{1'b0}};
          state_nxt_s   = ST_IDLE;
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r + TW'(1);
          state_nxt_s   = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        if (!uart_tx_busy) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_DONE;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        tmo_cnt_nxt_s = {TW{1'b0}};
      end
    endcase
  end

  // FSM state, arbitration history and registered uart_tx / ack outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      tmo_cnt_r    <= {TW{1'b0}};
      last_grant_r <= SRC_TRACE;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= 8'h00;
      trace_ack    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      tmo_cnt_r    <= tmo_cnt_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      uart_tx_en   <= tx_en_nxt_s;
      uart_tx_data <= tx_data_nxt_s;
      trace_ack    <= trace_ack_nxt_s;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= cpu_wr_data;
    end else begin
      fifo_mem_r[wr_ptr_r] <= fifo_mem_r[wr_ptr_r];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (cpu_ovf_clr) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

endmodule

// File: tb/tb_debug_uart_tx_sched.sv
// tb_debug_uart_tx_sched
// Directed stimulus with a scoreboard: each expected launch {ack, byte} is
// queued when stimulus is issued; a monitor pops and compares on every
// uart_tx_en pulse. A small uart_tx stub produces uart_tx_busy.
module tb_debug_uart_tx_sched;

  localparam int FIFO_DEPTH   = 4;
  localparam int BUSY_TIMEOUT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_wr_en = 1'b0;
  logic [7:0] cpu_wr_data = 8'h00;
  logic       cpu_ovf_clr = 1'b0;
  logic       trace_en = 1'b0;
  logic       trace_req = 1'b0;
  logic [7:0] trace_data = 8'h00;
  logic       trace_ack;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic       uart_tx_busy;
  logic [2:0] fifo_count;
  logic       fifo_full;
  logic       overflow;
  logic       sched_busy;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  int         cyc = 0;
  int         launch_cnt = 0;
  int         last_launch_cyc = 0;
  int         prev_launch_cyc = 0;
  logic       prev_en = 1'b0;

  // uart_tx stub controls
  logic force_busy = 1'b0;
  logic no_busy_mode = 1'b0;
  int   busy_cnt = 0;
  logic busy_r = 1'b0;

  assign uart_tx_busy = busy_r;

  debug_uart_tx_sched #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_wr_en   (cpu_wr_en),
    .cpu_wr_data (cpu_wr_data),
    .cpu_ovf_clr (cpu_ovf_clr),
    .trace_en    (trace_en),
    .trace_req   (trace_req),
    .trace_data  (trace_data),
    .trace_ack   (trace_ack),
    .uart_tx_en  (uart_tx_en),
    .uart_tx_data(uart_tx_data),
    .uart_tx_busy(uart_tx_busy),
    .fifo_count  (fifo_count),
    .fifo_full   (fifo_full),
    .overflow    (overflow),
    .sched_busy  (sched_busy)
  );

  always #5 clk = ~clk;

  // uart_tx stub: busy rises the edge after a launch and stays up 6 cycles.
  always @(posedge clk) begin
    if (rst) begin
      busy_r   <= 1'b0;
      busy_cnt <= 0;
    end else if (force_busy) begin
      busy_r <= 1'b1;
    end else if (no_busy_mode) begin
      busy_r <= 1'b0;
    end else if (uart_tx_en) begin
      busy_r   <= 1'b1;
      busy_cnt <= 6;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt <= 0;
      busy_r   <= 1'b0;
    end
  end

  // Monitor: compares every launch against the scoreboard queue.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_en = 1'b0;
      end else begin
        if (uart_tx_en) begin
          launch_cnt++;
          prev_launch_cyc = last_launch_cyc;
          last_launch_cyc = cyc;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL launch_unexpected: got ack=%0b data=%h, required no launch",
                     trace_ack, uart_tx_data);
          end else begin
            e = exp_q.pop_front();
            if ({trace_ack, uart_tx_data} !== e) begin
              errors++;
              $display("FAIL launch: got ack=%0b data=%h, required ack=%0b data=%h",
                       trace_ack, uart_tx_data, e[8], e[7:0]);
            end
          end
          checks++;
          if (prev_en) begin
            errors++;
            $display("FAIL back_to_back_en: got two consecutive cycles, required one");
          end
        end else if (trace_ack) begin
          checks++;
          errors++;
          $display("FAIL stray_ack: got trace_ack=1 without launch, required 0");
        end
        prev_en = uart_tx_en;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    while (!(exp_q.size() == 0 && sched_busy == 1'b0) && i < 300) begin
      tick();
      i++;
    end
    checks++;
    if (i >= 300) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending launches sched_busy=%0b, required 0/0",
               exp_q.size(), sched_busy);
    end
  endtask

  task automatic cpu_write(input logic [7:0] d);
    cpu_wr_en   = 1'b1;
    cpu_wr_data = d;
    tick();
    cpu_wr_en   = 1'b0;
  endtask

  initial begin
    int acks;
    int ens;
    int lc;
    int i;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_fifo_count", fifo_count, 3'd0);
    check("rst_tx_en", uart_tx_en, 1'b0);
    check("rst_tx_data", uart_tx_data, 8'h00);
    check("rst_trace_ack", trace_ack, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_sched_busy", sched_busy, 1'b0);
    check("rst_fifo_full", fifo_full, 1'b0);
    rst = 1'b0;
    tick();

    // Single CPU byte: launch two edges after the write
    exp_q.push_back({1'b0, 8'h41});
    cpu_write(8'h41);
    check("t1_count_after_push", fifo_count, 3'd1);
    check("t1_en_after_push", uart_tx_en, 1'b0);
    tick();
    check("t1_en_launch", uart_tx_en, 1'b1);
    check("t1_data_launch", uart_tx_data, 8'h41);
    check("t1_count_after_pop", fifo_count, 3'd0);
    tick();
    check("t1_en_one_cycle", uart_tx_en, 1'b0);
    wait_drain();

    // Overflow with uart_tx held busy
    force_busy = 1'b1;
    tick();
    for (int k = 1; k <= 5; k++) begin
      cpu_write(8'(k));
    end
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back({1'b0, 8'(k)});
    end
    check("t2_count_full", fifo_count, 3'd4);
    check("t2_full", fifo_full, 1'b1);
    check("t2_overflow", overflow, 1'b1);
    cpu_ovf_clr = 1'b1;
    tick();
    cpu_ovf_clr = 1'b0;
    check("t2_ovf_cleared", overflow, 1'b0);
    check("t2_count_kept", fifo_count, 3'd4);
    cpu_ovf_clr = 1'b1;
    cpu_write(8'h06);
    cpu_ovf_clr = 1'b0;
    check("t2_drop_beats_clr", overflow, 1'b1);
    check("t2_count_still_full", fifo_count, 3'd4);
    force_busy = 1'b0;
    wait_drain();
    check("t2_count_drained", fifo_count, 3'd0);
    check("t2_full_drained", fifo_full, 1'b0);
    check("t2_overflow_sticky", overflow, 1'b1);
    cpu_ovf_clr = 1'b1;
    tick();
    cpu_ovf_clr = 1'b0;
    check("t2_ovf_final_clear", overflow, 1'b0);

    // Round-robin between CPU and trace after reset (last_grant=TRACE)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    force_busy = 1'b1;
    tick();
    cpu_write(8'h11);
    cpu_write(8'h22);
    trace_en   = 1'b1;
    trace_req  = 1'b1;
    trace_data = 8'hA5;
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'hA5});
    exp_q.push_back({1'b0, 8'h22});
    force_busy = 1'b0;
    i = 0;
    while (trace_ack !== 1'b1 && i < 200) begin
      tick();
      i++;
    end
    check("t3_ack_seen", trace_ack, 1'b1);
    check("t3_ack_with_en", uart_tx_en, 1'b1);
    trace_req = 1'b0;
    wait_drain();
    trace_en = 1'b0;

    // Trace disabled: request is ignored
    trace_en   = 1'b0;
    trace_req  = 1'b1;
    trace_data = 8'h5A;
    acks = 0;
    ens  = 0;
    repeat (100) begin
      tick();
      if (trace_ack) acks++;
      if (uart_tx_en) ens++;
    end
    check("t4_no_ack", acks, 0);
    check("t4_no_launch", ens, 0);
    trace_req = 1'b0;

    // uart_tx never raises busy: each launch times out
    no_busy_mode = 1'b1;
    lc = launch_cnt;
    exp_q.push_back({1'b0, 8'h33});
    exp_q.push_back({1'b0, 8'h44});
    cpu_write(8'h33);
    cpu_write(8'h44);
    wait_drain();
    check("t5_launches", launch_cnt - lc, 2);
    check("t5_gap", last_launch_cyc - prev_launch_cyc, BUSY_TIMEOUT + 1);
    no_busy_mode = 1'b0;
    repeat (2) tick();

    // Reset during WAIT_DONE with two bytes queued
    exp_q.push_back({1'b0, 8'h61});
    cpu_write(8'h61);
    cpu_write(8'h62);
    cpu_write(8'h63);
    tick();
    check("t6_queued", fifo_count, 3'd2);
    check("t6_busy_before_rst", uart_tx_busy, 1'b1);
    rst = 1'b1;
    tick();
    check("t6_count", fifo_count, 3'd0);
    check("t6_en", uart_tx_en, 1'b0);
    check("t6_ack", trace_ack, 1'b0);
    check("t6_sched_busy", sched_busy, 1'b0);
    rst = 1'b0;
    lc = launch_cnt;
    repeat (30) tick();
    check("t6_no_more_launches", launch_cnt - lc, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
